udp_tx: RTL

- UDP transmit framer. Takes an application payload stream and prepends the 8-byte UDP header: source port, destination port, length, and a zero checksum (legal for IPv4).
- Sits between the application layer and the IP tx payload input. It mirrors the UDP receive path.
- Uses valid/ready handshakes on both sides.
- DATA_W=16 only; all byte ordering is network order, with the first wire byte in data[7:0].

---
 rtl/udp_tx_if.sv | 16 +
 rtl/udp_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/udp_tx_if.sv
// Beat-level valid/ready stream with start/last framing and a per-beat byte count.
// The same bundle serves the application side and the IP-tx side of the framer.
interface udp_tx_if #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = $clog2(DATA_W/8)+1
);
  logic              vld;
  logic              rdy;
  logic              start;
  logic              last;
  logic [DATA_W-1:0] dat;
  logic [LEN_W-1:0]  len;

  modport master (output vld, start, last, dat, len, input rdy);
  modport slave  (input vld, start, last, dat, len, output rdy);
endinterface

// File: rtl/udp_tx.sv
// UDP tx framer: prepends src/dst port, length and zero checksum; UDP_LEN_CHECK_EN adds payload length checking.
// Latency: first header beat one cycle after the start beat is seen; payload passes through combinationally.
// Backpressure: header beats hold while ip.rdy is low; payload ready follows ip.rdy; errored datagrams are drained.
module udp_tx #(
  parameter int                DATA_W   = 16,
  parameter int                LEN_W    = $clog2(DATA_W/8)+1,
  parameter int                PORT_W   = 16,
  parameter logic [PORT_W-1:0] SRC_PORT = 16'd18070,
  parameter logic [PORT_W-1:0] DST_PORT = 16'd18070
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cancel_i,
  input  logic [15:0] pld_len_i,
  udp_tx_if.slave     app,
  udp_tx_if.master    ip,
  output logic        err_o
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    HEAD  = 4'b0010,
    DATA  = 4'b0100,
    DRAIN = 4'b1000
  } state_t;

  localparam logic [15:0]      MAX_PLD  = 16'd65527;
  localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W/8);

  state_t      state, state_nxt;
  logic [1:0]  hcnt, hcnt_nxt;
  logic [15:0] udp_len;
  logic        err_nxt;
  logic        start_seen;

  assign start_seen = (state == IDLE) && app.vld && app.start;

`ifdef UDP_LEN_CHECK_EN
  logic [15:0] pcnt, pcnt_nxt, pay_sum, pld_exp;
  assign pay_sum = pcnt + 16'(app.len);
  assign pld_exp = udp_len - 16'd8;
`endif

  always_comb begin
    state_nxt = state;
    hcnt_nxt  = hcnt;
    err_nxt   = 1'b0;
    app.rdy   = 1'b0;
    ip.vld    = 1'b0;
    ip.start  = 1'b0;
    ip.last   = 1'b0;
    ip.dat    = '0;
    ip.len    = '0;
`ifdef UDP_LEN_CHECK_EN
    pcnt_nxt  = '0;
`endif
    case (state)
      IDLE: begin
        // The start beat stays on the app bus; it becomes the first payload beat.
        if (app.vld && app.start) begin
          if (pld_len_i == 16'd0 || pld_len_i > MAX_PLD) begin
            state_nxt = DRAIN;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = HEAD;
            hcnt_nxt  = 2'd0;
          end
        end
      end
      HEAD: begin
        ip.vld   = 1'b1;
        ip.len   = FULL_LEN;
        ip.start = (hcnt == 2'd0);
        case (hcnt)
          2'd0:    ip.dat = {SRC_PORT[7:0], SRC_PORT[15:8]};
          2'd1:    ip.dat = {DST_PORT[7:0], DST_PORT[15:8]};
          2'd2:    ip.dat = {udp_len[7:0], udp_len[15:8]};
          default: ip.dat = '0;
        endcase
        if (ip.rdy) begin
          hcnt_nxt = hcnt + 2'd1;
          if (hcnt == 2'd3) state_nxt = DATA;
        end
      end
      DATA: begin
        ip.vld  = app.vld;
        app.rdy = ip.rdy;
        ip.dat  = app.dat;
        ip.len  = app.len;
        ip.last = app.last;
`ifdef UDP_LEN_CHECK_EN
        pcnt_nxt = pcnt;
        // Declared length reached without last: terminate the datagram here.
        if (!app.last && pay_sum >= pld_exp) ip.last = 1'b1;
        if (app.vld && ip.rdy) begin
          pcnt_nxt = pay_sum;
          if (app.last) begin
            state_nxt = IDLE;
            err_nxt   = (pay_sum < pld_exp);
          end else if (pay_sum >= pld_exp) begin
            state_nxt = DRAIN;
            err_nxt   = 1'b1;
          end
        end
`else
        if (app.vld && ip.rdy && app.last) state_nxt = IDLE;
`endif
      end
      DRAIN: begin
        app.rdy = 1'b1;
        if (app.vld && app.last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A cancel landing on the closing payload beat lets the datagram complete cleanly.
    if (cancel_i) begin
      state_nxt = IDLE;
      if (state == HEAD || (state == DATA && !(app.vld && ip.rdy && app.last)))
        err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      hcnt    <= 2'd0;
      udp_len <= 16'd0;
      err_o   <= 1'b0;
`ifdef UDP_LEN_CHECK_EN
      pcnt    <= 16'd0;
`endif
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      err_o <= err_nxt;
      if (start_seen) udp_len <= pld_len_i + 16'd8;
`ifdef UDP_LEN_CHECK_EN
      pcnt  <= pcnt_nxt;
`endif
    end
  end

endmodule
